// File: rtl/uart_echo_buffer.sv
// UART echo buffer: received characters are queued in a FIFO and handed to the
// transmitter one at a time, optionally inserting LF after every CR.
`timescale 1ns/1ps
module uart_echo_buffer #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int CRLF_EXPAND  = 0,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [DATA_W-1:0]      RX_DATA,
   input  logic                   RX_READY,
   input  logic                   TX_IDLE,
   input  logic                   CLR_OVF,
   output logic [DATA_W-1:0]      TX_DATA,
   output logic                   TX_START,
   output logic [$clog2(DEPTH):0] FIFO_COUNT,
   output logic                   OVERFLOW,
   output logic [7:0]             DROP_COUNT
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [DATA_W-1:0] CR = DATA_W'(8'h0D);
   localparam logic [DATA_W-1:0] LF = DATA_W'(8'h0A);
   localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LF_ISSUE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic [TW-1:0]     tmr;
   logic              last_cr;
   logic              full, push, pop, drop;

   // A full FIFO still accepts a character when the issue side pops in the same cycle.
   assign full = (count == (AW+1)'(DEPTH));
   assign pop  = (state == IDLE) && (count != '0) && TX_IDLE;
   assign push = RX_READY && (!full || pop);
   assign drop = RX_READY && full && !pop;

   assign FIFO_COUNT = count;

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= RX_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A drop in the same cycle as a clear restarts the tally at one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OVERFLOW   <= 1'b0;
         DROP_COUNT <= 8'd0;
      end else if (drop) begin
         OVERFLOW <= 1'b1;
         if (CLR_OVF)                 DROP_COUNT <= 8'd1;
         else if (DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
      end else if (CLR_OVF) begin
         OVERFLOW   <= 1'b0;
         DROP_COUNT <= 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      TX_START  = 1'b0;
      case (state)
         IDLE:      if (pop) state_nxt = ISSUE;
         ISSUE: begin
            TX_START  = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: if (!TX_IDLE || (tmr == TMR_LAST)) state_nxt = WAIT_DONE;
         WAIT_DONE: if (TX_IDLE) state_nxt = ((CRLF_EXPAND != 0) && last_cr) ? LF_ISSUE : IDLE;
         LF_ISSUE:  state_nxt = ISSUE;
         default:   state_nxt = IDLE;
      endcase
   end

   // last_cr only remembers FIFO characters, so an inserted LF never chains.
   always_ff @(posedge CLK) begin
      if (RST) begin
         TX_DATA <= '0;
         last_cr <= 1'b0;
      end else if (pop) begin
         TX_DATA <= mem[rd_ptr];
         last_cr <= (mem[rd_ptr] == CR);
      end else if ((state == WAIT_DONE) && (state_nxt == LF_ISSUE)) begin
         TX_DATA <= LF;
         last_cr <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (state != WAIT_BUSY) tmr <= '0;
      else                    tmr <= tmr + TW'(1);
   end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: one plain instance and one with CRLF expansion,
// driven by the same receive stimulus, each with its own transmitter model.
`timescale 1ns/1ps
module tb_uart_echo_buffer;
   localparam int BUSY_TIMEOUT = 15;
   localparam int BUSY_LEN     = 10;

   logic       clk = 1'b0;
   logic       rst, rx_ready, clr_ovf, idle_force;
   logic [7:0] rx_data;
   int         mode = 1;
   int         cyc = 0;
   int         busy_a = 0, busy_b = 0;

   logic       idle_a, idle_b, start_a, start_b, ovf_a, ovf_b;
   logic [7:0] data_a, data_b, drop_a, drop_b;
   logic [4:0] cnt_a, cnt_b;

   logic [7:0] exp_a[$];
   logic [7:0] sent_a[$];
   logic [7:0] sent_b[$];
   int         t_a[$];
   int         compared = 0, mismatched = 0;

   uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .CRLF_EXPAND(0), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_READY(rx_ready), .TX_IDLE(idle_a),
      .CLR_OVF(clr_ovf), .TX_DATA(data_a), .TX_START(start_a), .FIFO_COUNT(cnt_a),
      .OVERFLOW(ovf_a), .DROP_COUNT(drop_a));

   uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .CRLF_EXPAND(1), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut_crlf (
      .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_READY(rx_ready), .TX_IDLE(idle_b),
      .CLR_OVF(clr_ovf), .TX_DATA(data_b), .TX_START(start_b), .FIFO_COUNT(cnt_b),
      .OVERFLOW(ovf_b), .DROP_COUNT(drop_b));

   always #5 clk = ~clk;

   // Transmitter model: mode 0 = idle forced by the bench, 1 = busy for BUSY_LEN
   // cycles after each start, 2 = never leaves idle.
   assign idle_a = (mode == 0) ? idle_force : (mode == 2) ? 1'b1 : (busy_a == 0);
   assign idle_b = (mode == 0) ? idle_force : (mode == 2) ? 1'b1 : (busy_b == 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start_a) busy_a <= BUSY_LEN; else if (busy_a != 0) busy_a <= busy_a - 1;
      if (start_b) busy_b <= BUSY_LEN; else if (busy_b != 0) busy_b <= busy_b - 1;
      if (start_a) begin
         sent_a.push_back(data_a);
         t_a.push_back(cyc);
      end
      if (start_b) sent_b.push_back(data_b);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      rx_data  = c;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   function automatic int expanded_len();
      int n;
      n = exp_a.size();
      foreach (exp_a[i]) if (exp_a[i] == 8'h0D) n++;
      return n;
   endfunction

   task automatic drain(input int budget);
      int nb;
      nb = expanded_len();
      for (int k = 0; k < budget; k++) begin
         if (sent_a.size() >= exp_a.size() && sent_b.size() >= nb) break;
         tick(1);
      end
      tick(40);
   endtask

   // Expected CRLF stream: the plain stream with 0x0A after every 0x0D.
   task automatic compare_stream(input string tag);
      logic [7:0] eb[$];
      foreach (exp_a[i]) begin
         eb.push_back(exp_a[i]);
         if (exp_a[i] == 8'h0D) eb.push_back(8'h0A);
      end
      check({tag, "_len"}, 32'(sent_a.size()), 32'(exp_a.size()));
      check({tag, "_crlf_len"}, 32'(sent_b.size()), 32'(eb.size()));
      for (int i = 0; i < exp_a.size() && i < sent_a.size(); i++)
         check($sformatf("%s[%0d]", tag, i), 32'(sent_a[i]), 32'(exp_a[i]));
      for (int i = 0; i < eb.size() && i < sent_b.size(); i++)
         check($sformatf("%s_crlf[%0d]", tag, i), 32'(sent_b[i]), 32'(eb[i]));
      check({tag, "_cnt_end"}, 32'(cnt_a), 32'(0));
      check({tag, "_crlf_cnt_end"}, 32'(cnt_b), 32'(0));
      exp_a.delete();
      sent_a.delete();
      sent_b.delete();
      t_a.delete();
   endtask

   initial begin
      logic [7:0] c;
      int         gap;
      rst = 1'b1; rx_ready = 1'b1; rx_data = 8'h55; clr_ovf = 1'b0; idle_force = 1'b1;
      mode = 1;
      tick(3);
      check("rst_start", 32'(start_a), 32'(0));
      check("rst_data", 32'(data_a), 32'(0));
      check("rst_cnt", 32'(cnt_a), 32'(0));
      check("rst_ovf", 32'(ovf_a), 32'(0));
      check("rst_drop", 32'(drop_a), 32'(0));
      check("rst_crlf_cnt", 32'(cnt_b), 32'(0));
      rx_ready = 1'b0;
      rst = 1'b0;
      tick(20);
      check("rst_rx_ignored", 32'(sent_a.size()), 32'(0));

      // single echo and latency
      send(8'h41);
      check("lat_n1_start", 32'(start_a), 32'(0));
      check("lat_n1_cnt", 32'(cnt_a), 32'(1));
      tick(1);
      check("lat_n2_start", 32'(start_a), 32'(1));
      check("lat_n2_data", 32'(data_a), 32'h41);
      check("lat_n2_cnt", 32'(cnt_a), 32'(0));
      check("lat_crlf_start", 32'(start_b), 32'(1));
      exp_a.push_back(8'h41);
      drain(500);
      compare_stream("echo");

      // burst into a stalled transmitter, then clear/saturation of drop status
      mode = 0; idle_force = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send(8'(i));
         if (i < 16) exp_a.push_back(8'(i));
      end
      check("burst_cnt", 32'(cnt_a), 32'(16));
      check("burst_ovf", 32'(ovf_a), 32'(1));
      check("burst_drop", 32'(drop_a), 32'(4));
      check("burst_crlf_drop", 32'(drop_b), 32'(4));
      clr_ovf = 1'b1;
      send(8'hEE);
      clr_ovf = 1'b0;
      check("clr_drop_wins_ovf", 32'(ovf_a), 32'(1));
      check("clr_drop_wins_cnt", 32'(drop_a), 32'(1));
      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      check("clr_ovf", 32'(ovf_a), 32'(0));
      check("clr_drop", 32'(drop_a), 32'(0));
      for (int i = 0; i < 260; i++) send(8'hEE);
      check("sat_drop", 32'(drop_a), 32'(255));
      check("sat_crlf_drop", 32'(drop_b), 32'(255));
      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      check("sat_clr", 32'(drop_a), 32'(0));
      mode = 1;
      drain(3000);
      compare_stream("burst");

      // full FIFO with push in the pop cycle
      mode = 0; idle_force = 1'b0;
      for (int i = 0; i < 16; i++) begin
         c = 8'($urandom);
         exp_a.push_back(c);
         send(c);
      end
      check("full_cnt", 32'(cnt_a), 32'(16));
      idle_force = 1'b1;
      c = 8'($urandom);
      exp_a.push_back(c);
      send(c);
      check("pushpop_cnt", 32'(cnt_a), 32'(16));
      check("pushpop_crlf_cnt", 32'(cnt_b), 32'(16));
      check("pushpop_ovf", 32'(ovf_a), 32'(0));
      check("pushpop_drop", 32'(drop_a), 32'(0));
      mode = 1;
      drain(3000);
      compare_stream("pushpop");

      // transmitter never leaves idle: each character times out
      mode = 2;
      send(8'h31); send(8'h32); send(8'h33);
      exp_a.push_back(8'h31); exp_a.push_back(8'h32); exp_a.push_back(8'h33);
      drain(500);
      for (int i = 1; i < t_a.size(); i++)
         check($sformatf("timeout_gap%0d", i), 32'(t_a[i] - t_a[i-1]), 32'(BUSY_TIMEOUT + 3));
      compare_stream("timeout");

      // reset while one character is in flight and five were queued
      mode = 0; idle_force = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
      check("rq_cnt", 32'(cnt_a), 32'(5));
      idle_force = 1'b1;
      tick(3);
      exp_a.push_back(8'h61);
      rst = 1'b1; rx_ready = 1'b1; rx_data = 8'h77;
      tick(1);
      rst = 1'b0; rx_ready = 1'b0;
      check("rq_cnt_after", 32'(cnt_a), 32'(0));
      check("rq_crlf_cnt_after", 32'(cnt_b), 32'(0));
      mode = 1;
      tick(60);
      compare_stream("rq_quiet");
      send(8'h7A);
      exp_a.push_back(8'h7A);
      drain(500);
      compare_stream("rq_new");

      // directed CR followed by a plain character
      send(8'h0D); send(8'h42);
      exp_a.push_back(8'h0D); exp_a.push_back(8'h42);
      drain(500);
      compare_stream("crlf");

      // random traffic, roughly one CR in four, spaced to stay below overflow
      for (int i = 0; i < 30; i++) begin
         c = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
         exp_a.push_back(c);
         send(c);
         gap = $urandom_range(20, 40);
         tick(gap);
      end
      drain(3000);
      check("rand_ovf", 32'(ovf_a), 32'(0));
      check("rand_crlf_ovf", 32'(ovf_b), 32'(0));
      compare_stream("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
